fp_round_unit: RTL



---
 rtl/Modules_pkg.sv | 49 ++++
 rtl/fp_round_incr.sv | 31 +++
 rtl/fp_round_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/Modules_pkg.sv
// Shared FP types and constants for the arithmetic units and the rounding stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package Modules_pkg;

  localparam int XLEN = 32;

  // IEEE-754 single precision
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  // Unrounded producer result: 23 fraction bits followed by guard, round, sticky
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [25:0] mantissa;
  } round_float_t;

  // RISC-V fflags ordering, NV in the top bit
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } round_mode_e;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  localparam logic [XLEN-1:0] P_INFTY       = 32'h7F80_0000;
  localparam logic [XLEN-1:0] N_INFTY       = 32'hFF80_0000;
  localparam logic [XLEN-1:0] MAX_FINITE    = 32'h7F7F_FFFF;
  localparam logic [XLEN-1:0] CANONICAL_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_round_incr.sv
// Rounding-increment decision for one fraction LSB given guard/round/sticky and mode.
// Latency: purely combinational.
// Backpressure: none.
module fp_round_incr
  import Modules_pkg::*;
(
  input  logic        sign,
  input  logic        lsb,
  input  logic        g,
  input  logic        r,
  input  logic        s,
  input  round_mode_e mode,
  output logic        inc,
  output logic        inexact
);

  // Any discarded bit makes the result inexact; the mode decides whether to bump the LSB
  always_comb begin
    inexact = g | r | s;
    inc     = 1'b0;
    case (mode)
      RNE:     inc = g & (r | s | lsb);
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & inexact;
      RUP:     inc = ~sign & inexact;
      RMM:     inc = g;
      default: inc = g & (r | s | lsb);
    endcase
  end

endmodule

// File: rtl/fp_round_unit.sv
// Single-precision rounding stage: applies the rounding mode, post-round carry, overflow/underflow and fflags.
// Latency: valid_o pulses 3 enabled cycles after the cycle valid_i is accepted; one op per 4 cycles.
// Backpressure: none; valid_i is only sampled while FREE (IDLE). Macro FP_ROUND_ALL_MODES_EN enables rm_i decoding.
module fp_round_unit
  import Modules_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en_i,
  input  logic        valid_i,
  input  logic [34:0] operand_i,
  input  logic [2:0]  rm_i,
  input  logic        overflow_i,
  input  logic        underflow_i,
  input  logic        invalid_op_i,
  output logic [31:0] result_o,
  output logic [4:0]  fflags_o,
  output logic        valid_o,
  output fu_state_e   fu_state_o
);

  typedef enum logic [1:0] {IDLE, ROUND, FINALIZE, VALID} state_e;

  state_e       state, state_nxt;
  round_float_t op_q;
  logic         ovf_q, unf_q, inv_q;
  logic [23:0]  sum_q;
  logic         nx_q;
  logic         accept;
  round_mode_e  mode;
  logic         bad_rm;
  logic         inc, inexact;
  float_t       res_d;
  fflags_t      flags_d;

  assign accept     = clk_en_i && (state == IDLE) && valid_i;
  assign fu_state_o = (state == IDLE) ? FREE : BUSY;

`ifdef FP_ROUND_ALL_MODES_EN
  logic [2:0] rm_q;

  // Capture the requested mode alongside the operand
  always_ff @(posedge clk_i) begin
    if (rst_i)       rm_q <= 3'b000;
    else if (accept) rm_q <= rm_i;
  end

  // Reserved encodings fall back to RNE and are reported as invalid
  assign bad_rm = (rm_q > 3'd4);
  assign mode   = bad_rm ? RNE : round_mode_e'(rm_q);
`else
  logic unused_rm;
  assign unused_rm = ^rm_i;
  assign bad_rm    = 1'b0;
  assign mode      = RNE;
`endif

  // State register; clk_en_i low freezes the FSM
  always_ff @(posedge clk_i) begin
    if (rst_i)         state <= IDLE;
    else if (clk_en_i) state <= state_nxt;
  end

  // Fixed four-step sequence, leaving IDLE only on a presented operand
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (valid_i) state_nxt = ROUND;
      ROUND:    state_nxt = FINALIZE;
      FINALIZE: state_nxt = VALID;
      VALID:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Operand and producer flags are held for the whole operation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inv_q <= 1'b0;
    end else if (accept) begin
      op_q  <= operand_i;
      ovf_q <= overflow_i;
      unf_q <= underflow_i;
      inv_q <= invalid_op_i;
    end
  end

  fp_round_incr u_incr (
    .sign    (op_q.sign),
    .lsb     (op_q.mantissa[3]),
    .g       (op_q.mantissa[2]),
    .r       (op_q.mantissa[1]),
    .s       (op_q.mantissa[0]),
    .mode    (mode),
    .inc     (inc),
    .inexact (inexact)
  );

  // ROUND: keep the 24-bit sum so the carry out of the fraction is visible later
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
      nx_q  <= 1'b0;
    end else if (clk_en_i && state == ROUND) begin
      sum_q <= {1'b0, op_q.mantissa[25:3]} + {23'd0, inc};
      nx_q  <= inexact;
    end
  end

  logic is_nan, is_inf, ovf_case, nan_case;
  assign is_nan   = (op_q.exponent == 8'hFF) && (op_q.mantissa[25:3] != 23'd0);
  assign is_inf   = (op_q.exponent == 8'hFF) && (op_q.mantissa[25:3] == 23'd0);
  assign nan_case = inv_q || is_nan;
  assign ovf_case = ovf_q || (sum_q[23] && op_q.exponent == 8'hFE);

  // FINALIZE result selection, highest priority first
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    if (nan_case) begin
      res_d      = CANONICAL_NAN;
      flags_d.nv = inv_q;
    end else if (is_inf) begin
      res_d = {op_q.sign, op_q.exponent, op_q.mantissa[25:3]};
    end else if (ovf_case) begin
      flags_d.of = 1'b1;
      flags_d.nx = 1'b1;
      case (mode)
        RTZ:     res_d = {op_q.sign, MAX_FINITE[30:0]};
        RDN:     res_d = op_q.sign ? N_INFTY : MAX_FINITE;
        RUP:     res_d = op_q.sign ? {1'b1, MAX_FINITE[30:0]} : P_INFTY;
        default: res_d = op_q.sign ? N_INFTY : P_INFTY;
      endcase
    end else if (unf_q || op_q.exponent == 8'h00) begin
      // Flush to signed zero; no subnormal support
      res_d      = {op_q.sign, 31'd0};
      flags_d.uf = (|op_q.mantissa) | unf_q;
      flags_d.nx = (|op_q.mantissa) | unf_q;
    end else begin
      res_d      = {op_q.sign, op_q.exponent + {7'd0, sum_q[23]}, sum_q[22:0]};
      flags_d.nx = nx_q;
    end
    if (!nan_case) flags_d.nv = bad_rm;
  end

  // Outputs load in FINALIZE and hold until the next one; valid_o marks the VALID cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o <= '0;
      fflags_o <= '0;
      valid_o  <= 1'b0;
    end else if (clk_en_i) begin
      valid_o <= (state == FINALIZE);
      if (state == FINALIZE) begin
        result_o <= res_d;
        fflags_o <= flags_d;
      end
    end
  end

endmodule
